// File: rtl/trap_controller.sv
// Trap controller: arbitrates exceptions, xRET and synchronized interrupts into a CSR context switch.
// Optional REQ-state watchdog enabled by defining TRAP_TIMEOUT_EN.
module trap_controller (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [3:0]  i_exc_req,
  input  logic [63:0] i_exc_pc,
  input  logic [2:0]  i_irq,
  input  logic [63:0] i_mie,
  input  logic        i_ie,
  input  logic [1:0]  i_privilege,
  input  logic [63:0] i_cur_pc,
  input  logic        i_ret_req,
  input  logic        i_de_cs,
  output logic        o_cs,
  output logic [63:0] o_cause,
  output logic [63:0] o_save_pc,
  output logic        o_stall,
  output logic        o_flush,
  output logic        o_trap_err
);

  typedef enum logic [1:0] {StIdle, StReq, StFlush} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [2:0]  r_irq_meta;
  logic [2:0]  r_irq_s;
  logic [63:0] r_cause;
  logic [63:0] r_save_pc;
  logic [2:0]  w_irq_en;
  logic        w_event;
  logic [63:0] w_cause;
  logic [63:0] w_save_pc;
  logic        w_unused_mie;

  assign w_unused_mie = ^{i_mie[63:12], i_mie[10:8], i_mie[6:4], i_mie[2:0]};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_irq_meta <= 3'b000;
      r_irq_s    <= 3'b000;
    end else begin
      r_irq_meta <= i_irq;
      r_irq_s    <= r_irq_meta;
    end
  end

  // Line order of w_irq_en: [0] software, [1] timer, [2] external.
  assign w_irq_en = {i_ie & r_irq_s[2] & i_mie[11],
                     i_ie & r_irq_s[1] & i_mie[7],
                     i_ie & r_irq_s[0] & i_mie[3]};

  always_comb begin
    w_event   = (|i_exc_req) | i_ret_req | (|w_irq_en);
    w_cause   = 64'd0;
    w_save_pc = i_cur_pc;
    if (i_exc_req[0]) begin
      w_cause   = 64'd2;
      w_save_pc = i_exc_pc;
    end else if (i_exc_req[1]) begin
      w_cause   = 64'd8 + {62'd0, i_privilege};
      w_save_pc = i_exc_pc;
    end else if (i_exc_req[2]) begin
      w_cause   = 64'd4;
      w_save_pc = i_exc_pc;
    end else if (i_exc_req[3]) begin
      w_cause   = 64'd6;
      w_save_pc = i_exc_pc;
    end else if (i_ret_req) begin
      w_cause   = 64'd0;
    end else if (w_irq_en[2]) begin
      w_cause   = {1'b1, 59'd0, 4'd11};
    end else if (w_irq_en[0]) begin
      w_cause   = {1'b1, 59'd0, 4'd3};
    end else if (w_irq_en[1]) begin
      w_cause   = {1'b1, 59'd0, 4'd7};
    end
  end

`ifdef TRAP_TIMEOUT_EN
  logic [2:0] r_tmo_cnt;
  logic       r_trap_err;
  logic       w_timeout;

  // Counter reads 0 on the first REQ cycle, 7 on the eighth.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tmo_cnt  <= 3'd0;
      r_trap_err <= 1'b0;
    end else begin
      r_trap_err <= w_timeout;
      if (r_state == StReq) begin
        r_tmo_cnt <= r_tmo_cnt + 3'd1;
      end else begin
        r_tmo_cnt <= 3'd0;
      end
    end
  end

  assign o_trap_err = r_trap_err;
`else
  assign o_trap_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= StIdle;
      r_cause   <= 64'd0;
      r_save_pc <= 64'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && w_event) begin
        r_cause   <= w_cause;
        r_save_pc <= w_save_pc;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
`ifdef TRAP_TIMEOUT_EN
    w_timeout    = 1'b0;
`endif
    o_cs         = 1'b0;
    o_stall      = 1'b0;
    o_flush      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_event) w_state_next = StReq;
      end
      StReq: begin
        o_cs    = 1'b1;
        o_stall = 1'b1;
        if (i_de_cs) begin
          w_state_next = StFlush;
`ifdef TRAP_TIMEOUT_EN
        end else if (r_tmo_cnt == 3'd7) begin
          w_state_next = StIdle;
          w_timeout    = 1'b1;
`endif
        end
      end
      StFlush: begin
        o_stall      = 1'b1;
        o_flush      = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_cause   = r_cause;
  assign o_save_pc = r_save_pc;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios plus randomized traps
// checked against a priority-table reference model.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  exc_req = '0;
  logic [63:0] exc_pc = '0;
  logic [2:0]  irq = '0;
  logic [63:0] mie = '0;
  logic        ie = 1'b0;
  logic [1:0]  priv = '0;
  logic [63:0] cur_pc = '0;
  logic        ret_req = 1'b0;
  logic        de_cs = 1'b0;
  logic        cs, stall, flush, trap_err;
  logic [63:0] cause, save_pc;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  trap_controller dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_exc_req   (exc_req),
    .i_exc_pc    (exc_pc),
    .i_irq       (irq),
    .i_mie       (mie),
    .i_ie        (ie),
    .i_privilege (priv),
    .i_cur_pc    (cur_pc),
    .i_ret_req   (ret_req),
    .i_de_cs     (de_cs),
    .o_cs        (cs),
    .o_cause     (cause),
    .o_save_pc   (save_pc),
    .o_stall     (stall),
    .o_flush     (flush),
    .o_trap_err  (trap_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exc_req = '0; irq = '0; ret_req = 1'b0; de_cs = 1'b0;
    ie = 1'b0; mie = '0; priv = '0;
  endtask

  // Reference: walk the architectural priority list; interrupts need 3 cycles to be seen.
  function automatic void ref_trap(input logic [3:0] e, input logic r, input logic [2:0] q,
                                   input logic en, input logic [63:0] m, input logic [1:0] p,
                                   input logic [63:0] epc, input logic [63:0] cpc,
                                   output bit hit, output logic [63:0] c,
                                   output logic [63:0] pc, output int lat);
    int exc_code[4];
    int irq_order[3];
    int irq_mie_bit[3];
    int irq_code[3];
    int l;
    exc_code = '{2, 8, 4, 6};
    irq_order = '{2, 0, 1};
    irq_mie_bit = '{3, 7, 11};
    irq_code = '{3, 7, 11};
    hit = 0; c = '0; pc = cpc; lat = 0;
    for (int k = 0; k < 4; k++) begin
      if (!hit && e[k]) begin
        hit = 1; lat = 1; pc = epc;
        c = 64'(exc_code[k] + ((k == 1) ? int'(p) : 0));
      end
    end
    if (!hit && r) begin
      hit = 1; lat = 1; c = '0;
    end
    for (int j = 0; j < 3; j++) begin
      l = irq_order[j];
      if (!hit && en && q[l] && m[irq_mie_bit[l]]) begin
        hit = 1; lat = 3;
        c = 64'h8000_0000_0000_0000 | 64'(irq_code[l]);
      end
    end
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #7;
    total++;
    if ({cs, stall, flush, trap_err} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got %b want 0000", {cs, stall, flush, trap_err});
    end
    total++;
    if (cause !== 64'd0 || save_pc !== 64'd0) begin
      bad++; $display("FAIL reset_regs got cause=%h pc=%h want 0/0", cause, save_pc);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
    total++;
    if ({cs, stall, flush} !== 3'b000) begin
      bad++; $display("FAIL reset_idle got %b want 000", {cs, stall, flush});
    end
  endtask

  task automatic test_ecall();
    exc_req = 4'b0010; priv = 2'd0; exc_pc = 64'h100; cur_pc = 64'h5555;
    step();
    exc_req = '0;
    total++;
    if ({cs, stall, flush} !== 3'b110 || cause !== 64'd8 || save_pc !== 64'h100) begin
      bad++; $display("FAIL ecall_req got cs/st/fl=%b cause=%h pc=%h want 110/8/100",
                      {cs, stall, flush}, cause, save_pc);
    end
    step();
    total++;
    if (cs !== 1'b1 || cause !== 64'd8) begin
      bad++; $display("FAIL ecall_hold got cs=%b cause=%h want 1/8", cs, cause);
    end
    de_cs = 1'b1;
    step();
    de_cs = 1'b0;
    total++;
    if ({cs, stall, flush} !== 3'b011) begin
      bad++; $display("FAIL ecall_flush got %b want 011", {cs, stall, flush});
    end
    step();
    total++;
    if ({cs, stall, flush} !== 3'b000 || save_pc !== 64'h100) begin
      bad++; $display("FAIL ecall_idle got %b pc=%h want 000/100", {cs, stall, flush}, save_pc);
    end
  endtask

  task automatic test_timer_irq();
    ie = 1'b1; mie = 64'h80; cur_pc = 64'h2000; irq = 3'b010;
    for (int c = 1; c <= 2; c++) begin
      step();
      total++;
      if (cs !== 1'b0) begin
        bad++; $display("FAIL irq_sync_delay cycle %0d got cs=%b want 0", c, cs);
      end
    end
    step();
    irq = '0;
    total++;
    if (cs !== 1'b1 || cause !== 64'h8000_0000_0000_0007 || save_pc !== 64'h2000) begin
      bad++; $display("FAIL timer_irq got cs=%b cause=%h pc=%h want 1/8000000000000007/2000",
                      cs, cause, save_pc);
    end
    de_cs = 1'b1;
    step();
    de_cs = 1'b0;
    step();
    step();
    total++;
    if (cs !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL timer_no_retrap got cs=%b stall=%b want 0/0", cs, stall);
    end
    clear_inputs();
  endtask

  task automatic test_exc_vs_irq();
    ie = 1'b1; mie = 64'h800; exc_pc = 64'h3000; cur_pc = 64'h4000;
    exc_req = 4'b1000; irq = 3'b100;
    step();
    exc_req = '0;
    total++;
    if (cs !== 1'b1 || cause !== 64'd6 || save_pc !== 64'h3000) begin
      bad++; $display("FAIL exc_first got cs=%b cause=%h pc=%h want 1/6/3000", cs, cause, save_pc);
    end
    de_cs = 1'b1;
    step();
    de_cs = 1'b0;
    total++;
    if (flush !== 1'b1) begin
      bad++; $display("FAIL exc_first_flush got %b want 1", flush);
    end
    step();
    total++;
    if (cs !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL gap_idle got cs=%b stall=%b want 0/0", cs, stall);
    end
    step();
    irq = '0;
    total++;
    if (cs !== 1'b1 || cause !== 64'h8000_0000_0000_000B || save_pc !== 64'h4000) begin
      bad++; $display("FAIL irq_second got cs=%b cause=%h pc=%h want 1/800000000000000b/4000",
                      cs, cause, save_pc);
    end
    de_cs = 1'b1;
    step();
    de_cs = 1'b0;
    repeat (3) step();
    clear_inputs();
  endtask

  task automatic test_irq_gating();
    ie = 1'b0; mie = '1; irq = 3'b111;
    for (int c = 0; c < 6; c++) begin
      step();
      total++;
      if (cs !== 1'b0 || stall !== 1'b0) begin
        bad++; $display("FAIL ie_off cycle %0d got cs=%b stall=%b want 0/0", c, cs, stall);
      end
    end
    irq = '0;
    repeat (3) step();
    ie = 1'b1; mie = 64'h8; irq = 3'b001;
    step();
    step();
    ie = 1'b0;
    step();
    total++;
    if (cs !== 1'b0) begin
      bad++; $display("FAIL ie_drop got cs=%b want 0", cs);
    end
    irq = '0;
    repeat (3) step();
    clear_inputs();
  endtask

  task automatic test_timeout();
    int cs_cycles;
    int err_cycles;
    bit flush_seen;
    cs_cycles = 0; err_cycles = 0; flush_seen = 0;
    exc_req = 4'b0001; exc_pc = 64'hC0;
    step();
    exc_req = '0;
`ifdef TRAP_TIMEOUT_EN
    for (int c = 0; c < 14; c++) begin
      if (cs === 1'b1) cs_cycles++;
      if (trap_err === 1'b1) err_cycles++;
      if (flush === 1'b1) flush_seen = 1;
      step();
    end
    total++;
    if (cs_cycles != 8) begin
      bad++; $display("FAIL timeout_cs_len got %0d want 8", cs_cycles);
    end
    total++;
    if (err_cycles != 1 || flush_seen) begin
      bad++; $display("FAIL timeout_err got err=%0d flush=%0d want 1/0", err_cycles, flush_seen);
    end
`else
    for (int c = 0; c < 20; c++) begin
      if (cs === 1'b1) cs_cycles++;
      if (trap_err !== 1'b0) err_cycles++;
      if (flush === 1'b1) flush_seen = 1;
      step();
    end
    total++;
    if (cs_cycles != 20 || err_cycles != 0 || flush_seen) begin
      bad++; $display("FAIL wait_forever got cs=%0d err=%0d flush=%0d want 20/0/0",
                      cs_cycles, err_cycles, flush_seen);
    end
    de_cs = 1'b1;
    step();
    de_cs = 1'b0;
    step();
`endif
    total++;
    if (cs !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL timeout_end got cs=%b stall=%b want 0/0", cs, stall);
    end
  endtask

  task automatic test_reset_mid_req();
    exc_req = 4'b0001; exc_pc = 64'hABC;
    step();
    exc_req = '0;
    total++;
    if (cs !== 1'b1) begin
      bad++; $display("FAIL mid_req_enter got cs=%b want 1", cs);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({cs, stall, flush} !== 3'b000 || cause !== 64'd0 || save_pc !== 64'd0) begin
      bad++; $display("FAIL async_reset got %b cause=%h pc=%h want 000/0/0",
                      {cs, stall, flush}, cause, save_pc);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
    total++;
    if (cs !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle got cs=%b want 0", cs);
    end
    exc_req = 4'b1000; exc_pc = 64'h77;
    step();
    exc_req = '0;
    total++;
    if (cs !== 1'b1 || cause !== 64'd6 || save_pc !== 64'h77) begin
      bad++; $display("FAIL post_reset_trap got cs=%b cause=%h pc=%h want 1/6/77",
                      cs, cause, save_pc);
    end
    de_cs = 1'b1;
    step();
    de_cs = 1'b0;
    step();
  endtask

  task automatic test_random();
    bit hit;
    logic [63:0] ec, ep;
    int lat;
    int d;
    for (int it = 0; it < 40; it++) begin
      exc_req = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      ret_req = ($urandom_range(0, 4) == 0);
      irq = 3'($urandom);
      ie = ($urandom_range(0, 3) != 0);
      mie = {$urandom, $urandom};
      priv = 2'($urandom);
      exc_pc = {$urandom, $urandom};
      cur_pc = {$urandom, $urandom};
      ref_trap(exc_req, ret_req, irq, ie, mie, priv, exc_pc, cur_pc, hit, ec, ep, lat);
      for (int c = 1; c <= 3; c++) begin
        step();
        if (hit && c == lat) begin
          total++;
          if (cs !== 1'b1 || cause !== ec || save_pc !== ep) begin
            bad++; $display("FAIL rand_take it=%0d got cs=%b cause=%h pc=%h want 1/%h/%h",
                            it, cs, cause, save_pc, ec, ep);
          end
          break;
        end
        total++;
        if (cs !== 1'b0 || stall !== 1'b0) begin
          bad++; $display("FAIL rand_idle it=%0d cycle %0d got cs=%b stall=%b want 0/0",
                          it, c, cs, stall);
        end
      end
      irq = '0;
      if (!hit) begin
        clear_inputs();
        repeat (3) step();
        continue;
      end
      d = $urandom_range(0, 4);
      for (int c = 0; c < d; c++) begin
        exc_req = 4'($urandom); ret_req = 1'($urandom); priv = 2'($urandom);
        exc_pc = {$urandom, $urandom}; cur_pc = {$urandom, $urandom};
        step();
        total++;
        if (cs !== 1'b1 || cause !== ec || save_pc !== ep) begin
          bad++; $display("FAIL rand_hold it=%0d got cs=%b cause=%h pc=%h want 1/%h/%h",
                          it, cs, cause, save_pc, ec, ep);
        end
      end
      de_cs = 1'b1;
      step();
      clear_inputs();
      total++;
      if ({cs, stall, flush} !== 3'b011 || cause !== ec) begin
        bad++; $display("FAIL rand_flush it=%0d got %b cause=%h want 011/%h",
                        it, {cs, stall, flush}, cause, ec);
      end
      step();
      total++;
      if ({cs, stall, flush} !== 3'b000) begin
        bad++; $display("FAIL rand_back_idle it=%0d got %b want 000", it, {cs, stall, flush});
      end
    end
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_timer_irq();
    test_exc_vs_irq();
    test_irq_gating();
    test_timeout();
    test_reset_mid_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
